iocontroller_mc: RTL and testbench

Multi-channel, width-parametrised successor of the single-port CPU I/O syscall controller. It sits between the core's accumulator/`runio` strobe and `NCHAN` peripheral channels, each with its own four-phase read/write/ack handshake. It decodes the syscall word (operation plus channel number) and drives one channel's strobes. It reports completion with a one-cycle `iobusy` drop and adds a per-transfer ack timeout and an error flag for bad requests.

---
 rtl/iocontroller_mc.sv | 153 +++++++++++++++
 tb/tb_iocontroller_mc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/iocontroller_mc.sv
// iocontroller_mc: multi-channel syscall I/O controller.
// Decodes the accumulator syscall word (op + channel), drives one channel's
// one-hot read/write strobe, waits for that channel's ack (with optional
// timeout), then signals completion with a one-cycle iobusy drop.
//
// Handshake: a request is taken when runio=1 is sampled in DECODE; the
// selected strobe stays high until ioack[ch] is sampled high (or the timeout
// expires); iobusy then drops for exactly one cycle; the controller returns
// to DECODE only once ioack[ch] has been sampled low again.
module iocontroller_mc #(
  parameter int WIDTH   = 16,
  parameter int NCHAN   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             runio,
  input  logic [WIDTH-1:0] acc,
  input  logic [NCHAN-1:0] ioack,
  output logic             iobusy,
  output logic [NCHAN-1:0] io_read,
  output logic [NCHAN-1:0] io_write,
  output logic             acc_write,
  output logic             ioerr,
  output logic             halted,
  output logic [1:0]       dbg_state
);

  localparam int CW  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int CTW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  // The timeout fires on the edge at which the counter would reach TIMEOUT,
  // so the strobe is held for exactly TIMEOUT WAITACK cycles.
  localparam logic [CTW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CTW'(TIMEOUT - 1);
  localparam logic [CTW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_DECODE    = 2'd0,
    S_WAITACK   = 2'd1,
    S_WAITREADY = 2'd2,
    S_HALT      = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    ch_q;
  logic             bad_q;
  logic [CTW-1:0]   cnt;

  logic [1:0]       op;
  logic [CW-1:0]    chan;
  logic [4:0]       chan_ext;
  logic [4:0]       ch_q_ext;
  logic             upper_zero;
  logic             legal;
  logic [NCHAN-1:0] chan_mask;
  logic [NCHAN-1:0] ch_q_mask;
  logic             ack_sel;

  assign dbg_state = state;

  // Syscall word decode and one-hot channel masks for request and latched channel.
  always_comb begin
    op         = acc[1:0];
    chan       = acc[CW+1:2];
    chan_ext   = 5'(chan);
    ch_q_ext   = 5'(ch_q);
    upper_zero = ((acc >> (CW + 2)) == '0);
    legal      = upper_zero && (chan_ext < 5'(NCHAN));
    chan_mask  = '0;
    ch_q_mask  = '0;
    for (int i = 0; i < NCHAN; i++) begin
      chan_mask[i] = (chan_ext == 5'(i));
      ch_q_mask[i] = (ch_q_ext == 5'(i));
    end
    ack_sel = |(ioack & ch_q_mask);
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_DECODE;
      ch_q      <= '0;
      bad_q     <= 1'b0;
      cnt       <= '0;
      iobusy    <= 1'b1;
      io_read   <= '0;
      io_write  <= '0;
      acc_write <= 1'b0;
      ioerr     <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_DECODE: begin
          if (runio) begin
            ch_q  <= chan;
            bad_q <= 1'b0;
            if (acc == '0) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else if (legal && op == 2'd1) begin
              io_read   <= chan_mask;
              acc_write <= 1'b1;
              cnt       <= '0;
              state     <= S_WAITACK;
            end else if (legal && op == 2'd2) begin
              io_write <= chan_mask;
              cnt      <= '0;
              state    <= S_WAITACK;
            end else begin
              // Bad request: no strobe, immediate error completion.
              iobusy <= 1'b0;
              ioerr  <= 1'b1;
              bad_q  <= 1'b1;
              state  <= S_WAITREADY;
            end
          end
        end
        S_WAITACK: begin
          cnt <= (cnt == CNT_MAX) ? cnt : cnt + CTW'(1);
          if (ack_sel) begin
            io_read   <= '0;
            io_write  <= '0;
            acc_write <= 1'b0;
            iobusy    <= 1'b0;
            state     <= S_WAITREADY;
          end else if (TO_EN && cnt == TO_LAST) begin
            io_read   <= '0;
            io_write  <= '0;
            acc_write <= 1'b0;
            iobusy    <= 1'b0;
            ioerr     <= 1'b1;
            state     <= S_WAITREADY;
          end
        end
        S_WAITREADY: begin
          iobusy <= 1'b1;
          ioerr  <= 1'b0;
          // After a bad request the channel never acked, so do not wait on it.
          if (bad_q || !ack_sel) begin
            bad_q <= 1'b0;
            state <= S_DECODE;
          end
        end
        S_HALT: begin
          halted <= 1'b1;
          iobusy <= 1'b1;
        end
        default: state <= S_DECODE;
      endcase
    end
  end

endmodule

// File: tb/tb_iocontroller_mc.sv
// Directed bench for iocontroller_mc: two instances (NCHAN=4 and NCHAN=3,
// both TIMEOUT=8). Inputs change and outputs are sampled on falling edges.
module tb_iocontroller_mc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        runio4 = 1'b0;
  logic [15:0] acc4 = '0;
  logic [3:0]  ioack4 = '0;
  logic        busy4, aw4, err4, halt4;
  logic [3:0]  rd4, wr4;
  logic [1:0]  st4;

  logic        runio3 = 1'b0;
  logic [15:0] acc3 = '0;
  logic [2:0]  ioack3 = '0;
  logic        busy3, aw3, err3, halt3;
  logic [2:0]  rd3, wr3;
  logic [1:0]  st3;

  int n_tests = 0;
  int n_fail  = 0;

  iocontroller_mc #(.WIDTH(16), .NCHAN(4), .TIMEOUT(8)) u_dut4 (
    .clock(clock), .reset(reset), .runio(runio4), .acc(acc4), .ioack(ioack4),
    .iobusy(busy4), .io_read(rd4), .io_write(wr4), .acc_write(aw4),
    .ioerr(err4), .halted(halt4), .dbg_state(st4)
  );

  iocontroller_mc #(.WIDTH(16), .NCHAN(3), .TIMEOUT(8)) u_dut3 (
    .clock(clock), .reset(reset), .runio(runio3), .acc(acc3), .ioack(ioack3),
    .iobusy(busy3), .io_read(rd3), .io_write(wr3), .acc_write(aw3),
    .ioerr(err3), .halted(halt3), .dbg_state(st3)
  );

  // Clock generation
  always #5 clock = ~clock;

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic b, input logic [3:0] r,
                      input logic [3:0] w, input logic a, input logic e, input logic h);
    chk({tag, "_iobusy"}, 32'(busy4), 32'(b));
    chk({tag, "_io_read"}, 32'(rd4), 32'(r));
    chk({tag, "_io_write"}, 32'(wr4), 32'(w));
    chk({tag, "_acc_write"}, 32'(aw4), 32'(a));
    chk({tag, "_ioerr"}, 32'(err4), 32'(e));
    chk({tag, "_halted"}, 32'(halt4), 32'(h));
  endtask

  task automatic chk3(input string tag, input logic b, input logic e);
    chk({tag, "_iobusy"}, 32'(busy3), 32'(b));
    chk({tag, "_ioerr"}, 32'(err3), 32'(e));
    chk({tag, "_io_read"}, 32'(rd3), 32'd0);
    chk({tag, "_io_write"}, 32'(wr3), 32'd0);
    chk({tag, "_acc_write"}, 32'(aw3), 32'd0);
  endtask

  initial begin
    // Reset
    #1 reset = 1'b0;
    cyc(); cyc();
    chk4("rst4", 1, 4'h0, 4'h0, 0, 0, 0);
    chk("rst4_state", 32'(st4), 32'd0);
    chk3("rst3", 1, 0);
    reset = 1'b1;
    cyc();

    // LOAD ch0, ack after 3 cycles
    acc4 = 16'h0001; runio4 = 1'b1;
    cyc();
    runio4 = 1'b0;
    chk4("ld0_strobe", 1, 4'h1, 4'h0, 1, 0, 0);
    cyc(); cyc();
    chk4("ld0_hold", 1, 4'h1, 4'h0, 1, 0, 0);
    ioack4 = 4'h1;
    cyc();
    chk4("ld0_done", 0, 4'h0, 4'h0, 0, 0, 0);
    ioack4 = 4'h0;
    cyc();
    chk4("ld0_idle", 1, 4'h0, 4'h0, 0, 0, 0);
    chk("ld0_state", 32'(st4), 32'd0);

    // STORE ch3 with ack held 4 cycles; stray ack on ch1 ignored
    acc4 = 16'h000E; runio4 = 1'b1;
    cyc();
    runio4 = 1'b0;
    chk4("st3_strobe", 1, 4'h0, 4'h8, 0, 0, 0);
    ioack4 = 4'h8;
    cyc();
    chk4("st3_done", 0, 4'h0, 4'h0, 0, 0, 0);
    cyc();
    chk4("st3_wr1", 1, 4'h0, 4'h0, 0, 0, 0);
    chk("st3_wr1_state", 32'(st4), 32'd2);
    ioack4 = 4'hA;
    runio4 = 1'b1; acc4 = 16'h0009;
    cyc();
    chk4("st3_wr2", 1, 4'h0, 4'h0, 0, 0, 0);
    chk("st3_wr2_state", 32'(st4), 32'd2);
    runio4 = 1'b0;
    cyc();
    ioack4 = 4'h2;
    cyc();
    chk("st3_release_state", 32'(st4), 32'd0);
    chk4("st3_release", 1, 4'h0, 4'h0, 0, 0, 0);
    acc4 = 16'h0009; runio4 = 1'b1;
    cyc();
    runio4 = 1'b0;
    chk4("ld2_strobe", 1, 4'h4, 4'h0, 1, 0, 0);
    cyc();
    chk4("ld2_other_ack", 1, 4'h4, 4'h0, 1, 0, 0);
    ioack4 = 4'h4;
    cyc();
    chk4("ld2_done", 0, 4'h0, 4'h0, 0, 0, 0);
    ioack4 = 4'h0;
    cyc();
    chk4("ld2_idle", 1, 4'h0, 4'h0, 0, 0, 0);

    // LOAD ch1 timeout after 8 WAITACK cycles
    acc4 = 16'h0005; runio4 = 1'b1;
    cyc();
    runio4 = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    chk4("to_hold", 1, 4'h2, 4'h0, 1, 0, 0);
    cyc();
    chk4("to_fire", 0, 4'h0, 4'h0, 0, 1, 0);
    cyc();
    chk4("to_after", 1, 4'h0, 4'h0, 0, 0, 0);
    chk("to_after_state", 32'(st4), 32'd0);

    // Ack on the timeout cycle wins
    acc4 = 16'h0005; runio4 = 1'b1;
    cyc();
    runio4 = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    chk4("tack_hold", 1, 4'h2, 4'h0, 1, 0, 0);
    ioack4 = 4'h2;
    cyc();
    chk4("tack_fire", 0, 4'h0, 4'h0, 0, 0, 0);
    ioack4 = 4'h0;
    cyc();
    chk4("tack_after", 1, 4'h0, 4'h0, 0, 0, 0);

    // Invalid requests on the 3-channel instance
    acc3 = 16'h000D; runio3 = 1'b1;
    cyc();
    runio3 = 1'b0;
    chk3("bad_ch3", 0, 1);
    cyc();
    chk3("bad_ch3_after", 1, 0);
    chk("bad_ch3_state", 32'(st3), 32'd0);
    acc3 = 16'h0003; runio3 = 1'b1;
    cyc();
    runio3 = 1'b0;
    chk3("bad_op3", 0, 1);
    cyc();
    chk3("bad_op3_after", 1, 0);
    acc3 = 16'h0100; runio3 = 1'b1; ioack3 = 3'b111;
    cyc();
    runio3 = 1'b0;
    chk3("bad_upper", 0, 1);
    cyc();
    chk3("bad_upper_after", 1, 0);
    chk("bad_upper_state", 32'(st3), 32'd0);
    ioack3 = 3'b000;

    // Asynchronous reset mid-WAITACK, then STORE ch0 completes
    acc4 = 16'h0002; runio4 = 1'b1;
    cyc();
    runio4 = 1'b0;
    chk4("ar_strobe", 1, 4'h0, 4'h1, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk4("ar_async", 1, 4'h0, 4'h0, 0, 0, 0);
    cyc();
    reset = 1'b1;
    cyc();
    acc4 = 16'h0002; runio4 = 1'b1;
    cyc();
    runio4 = 1'b0;
    chk4("ar_st0", 1, 4'h0, 4'h1, 0, 0, 0);
    ioack4 = 4'h1;
    cyc();
    chk4("ar_st0_done", 0, 4'h0, 4'h0, 0, 0, 0);
    ioack4 = 4'h0;
    cyc();
    chk4("ar_st0_idle", 1, 4'h0, 4'h0, 0, 0, 0);

    // HALT is terminal until reset
    acc4 = 16'h0000; runio4 = 1'b1;
    cyc();
    chk4("halt", 1, 4'h0, 4'h0, 0, 0, 1);
    chk("halt_state", 32'(st4), 32'd3);
    acc4 = 16'h0001;
    cyc(); cyc();
    chk4("halt_stuck", 1, 4'h0, 4'h0, 0, 0, 1);
    runio4 = 1'b0;
    reset = 1'b0;
    cyc();
    chk4("halt_reset", 1, 4'h0, 4'h0, 0, 0, 0);
    reset = 1'b1;
    cyc();
    chk("halt_recover_state", 32'(st4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
